// File: rtl/monim_ovl_mux.sv
// In-line video overlay: draws CH_N status words as binary bar graphs on a PAT_W x PAT_H stream.
// Optional MONIM_OVL_LINE_CHK_EN adds a sticky line-length error flag (line_err_o).

module monim_ovl_shadow #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i)  q <= '0;
    else if (ld) q <= d;
endmodule

module monim_ovl_mux #(
  parameter int               PIX_W  = 8,
  parameter int               PAT_W  = 800,
  parameter int               PAT_H  = 600,
  parameter int               CH_N   = 2,
  parameter int               DATA_W = 32,
  parameter int               BIT_W  = 8,
  parameter int               BAR_H  = 16,
  parameter int               ORG_X  = 16,
  parameter int               ORG_Y  = 16,
  parameter logic [PIX_W-1:0] FG_VAL = '1,
  parameter logic [PIX_W-1:0] BG_VAL = '0
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [PIX_W-1:0]       s_axi_data_i,
  input  logic                   s_axi_valid_i,
  output logic                   s_axi_ready_o,
  input  logic                   s_axi_last_i,
  output logic [PIX_W-1:0]       m_axi_data_o,
  output logic                   m_axi_valid_o,
  input  logic                   m_axi_ready_i,
  output logic                   m_axi_last_o,
  input  logic [CH_N*DATA_W-1:0] data_i
`ifdef MONIM_OVL_LINE_CHK_EN
  ,
  output logic                   line_err_o
`endif
);
  localparam int XW  = $clog2(PAT_W + 1);
  localparam int YW  = $clog2(PAT_H + 1);
  localparam int CW  = $clog2(DATA_W);
  localparam int CHW = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int BSH = $clog2(BIT_W);

  localparam logic [XW-1:0] X_LO  = XW'(ORG_X);
  localparam logic [XW-1:0] X_HI  = XW'(ORG_X + DATA_W*BIT_W);
  localparam logic [XW-1:0] X_MAX = XW'(PAT_W - 1);
  localparam logic [YW-1:0] Y_LO  = YW'(ORG_Y);
  localparam logic [YW-1:0] Y_HI  = YW'(ORG_Y + CH_N*BAR_H);
  localparam logic [YW-1:0] Y_MAX = YW'(PAT_H - 1);
  localparam logic [YW-1:0] BAR   = YW'(BAR_H);

  logic [XW-1:0]                x, dx;
  logic [YW-1:0]                y, dy;
  logic [CHW-1:0]               ch;
  logic [CW-1:0]                col;
  logic                         acc, frame_end, in_win, bit_on;
  logic [PIX_W-1:0]             pix;
  logic [CH_N-1:0][DATA_W-1:0]  shadow;

  assign s_axi_ready_o = !m_axi_valid_o || m_axi_ready_i;
  assign acc           = s_axi_valid_i && s_axi_ready_o;
  assign frame_end     = acc && s_axi_last_i && (y == Y_MAX);

  // Snapshot all channels together at the frame boundary so a frame never tears.
  for (genvar k = 0; k < CH_N; k++) begin : g_sh
    monim_ovl_shadow #(.DATA_W(DATA_W)) u_sh (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .ld    (frame_end),
      .d     (data_i[k*DATA_W +: DATA_W]),
      .q     (shadow[k])
    );
  end

  always_comb begin
    dx     = x - X_LO;
    dy     = y - Y_LO;
    col    = CW'(dx >> BSH);
    ch     = CHW'(dy / BAR);
    in_win = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    bit_on = shadow[ch][CW'(DATA_W-1) - col];
    pix    = in_win ? (bit_on ? FG_VAL : BG_VAL) : s_axi_data_i;
  end

  // x saturates on an over-long line so a missing last cannot wrap into the window.
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      x <= '0;
      y <= '0;
    end else if (acc) begin
      if (s_axi_last_i) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else if (x != X_MAX) begin
        x <= x + 1'b1;
      end
    end

  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      m_axi_valid_o <= 1'b0;
      m_axi_data_o  <= '0;
      m_axi_last_o  <= 1'b0;
    end else if (acc) begin
      m_axi_valid_o <= 1'b1;
      m_axi_data_o  <= pix;
      m_axi_last_o  <= s_axi_last_i;
    end else if (m_axi_ready_i) begin
      m_axi_valid_o <= 1'b0;
    end

`ifdef MONIM_OVL_LINE_CHK_EN
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i)
      line_err_o <= 1'b0;
    else if (acc && ((s_axi_last_i && x != X_MAX) || (!s_axi_last_i && x == X_MAX)))
      line_err_o <= 1'b1;
`endif

endmodule

// File: doc/monim_ovl_mux.md
Name: monim_ovl_mux

Overview:
- Parametrised successor to the two-channel monitor: in-line video-stream overlay that renders CH_N status words of DATA_W bits as binary bar graphs on a PAT_W x PAT_H pattern.
- Sits between the upstream pattern source (slave stream) and the downstream sink (master stream).
- Status words are snapshotted once per frame, so the overlay never tears.
- Pixel width, channel count, word width, cell size and overlay origin are all parameters.

Parameters:
- PIX_W, 8: pixel/data width of both streams.
- PAT_W, 800: pixels per line.
- PAT_H, 600: lines per frame.
- CH_N, 2: number of status channels, 1..8.
- DATA_W, 32: bits per status word.
- BIT_W, 8: pixel width of one bit cell; power of two.
- BAR_H, 16: line height of one channel bar.
- ORG_X, 16: overlay left column. Must satisfy ORG_X + DATA_W*BIT_W <= PAT_W.
- ORG_Y, 16: overlay top line. Must satisfy ORG_Y + CH_N*BAR_H <= PAT_H.
- FG_VAL, all ones: pixel value for a bit = 1.
- BG_VAL, 0: pixel value for a bit = 0.

Ports:
- clk_i, in, 1: clock.
- arst_i, in, 1: asynchronous active-high reset.
- s_axi_data_i, in, PIX_W: input pixel.
- s_axi_valid_i, in, 1: input valid.
- s_axi_ready_o, out, 1: input ready.
- s_axi_last_i, in, 1: last pixel of line.
- m_axi_data_o, out, PIX_W: output pixel.
- m_axi_valid_o, out, 1: output valid.
- m_axi_ready_i, in, 1: output ready.
- m_axi_last_o, out, 1: last pixel of line.
- data_i, in, CH_N*DATA_W: live status words; channel k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high (clk_i, arst_i).
- Reset values:
  - m_axi_valid_o = 0, m_axi_data_o = 0, m_axi_last_o = 0.
  - x = 0, y = 0.
  - Shadow words = 0.
  - s_axi_ready_o = 1 (pipeline stage empty).
- Pipeline:
  - Single registered stage, latency 1 accepted beat.
  - s_axi_ready_o = !m_axi_valid_o || m_axi_ready_i, combinational.
  - Beat accepted when s_axi_valid_i && s_axi_ready_o; the output register loads data, last and valid = 1.
  - Output emptied (valid = 0) when m_axi_ready_i is high and no new beat is accepted that cycle.
  - Output data/last held stable while valid && !ready.
- Position counters advance only on an accepted beat:
  - x increments. On last: x = 0 and y increments.
  - On last with y == PAT_H-1: y = 0, and every shadow word loads from data_i in that same cycle (frame boundary).
  - x saturates at PAT_W-1 if last is missing; further beats hold x.
- Overlay window: ORG_X <= x < ORG_X + DATA_W*BIT_W and ORG_Y <= y < ORG_Y + CH_N*BAR_H.
  - Channel ch = (y - ORG_Y) / BAR_H. Column c = (x - ORG_X) / BIT_W, computed by shift.
  - Displayed bit = shadow[ch][DATA_W-1-c], MSB leftmost.
  - Output pixel = FG_VAL if bit = 1, else BG_VAL.
  - Outside the window the pixel passes through unchanged. last always passes through.
- First frame after reset: shadows are 0, so the overlay shows all BG_VAL.
- Reset mid-frame: counters return to 0 and the next accepted beat is treated as pixel (0,0). The upstream is responsible for realignment.
- Simultaneous frame-boundary snapshot and data_i change: the value present on data_i in the accepting cycle is captured.

Optional Feature:
- Macro: MONIM_OVL_LINE_CHK_EN.
- Defined:
  - Adds output line_err_o (1 bit, reset 0).
  - line_err_o is sticky, set when an accepted last arrives with x != PAT_W-1, or a beat is accepted with x == PAT_W-1 and last = 0.
  - Cleared only by arst_i.
- Undefined: port absent, no check logic.

Test Plan (default parameters; window is x 16..271, ch0 y 16..31, ch1 y 32..47):
- Frame 0 with data_i ch0 = 0x80000001, then frame 1 -> line 16:
  - x 16..23 = 0xFF, x 24..263 = 0x00, x 264..271 = 0xFF.
  - Frame 0 at the same positions is all 0x00.
- Input pixel 0x5A at (300,16) and at (100,100) -> output 0x5A at both, last bits identical to input.
- ch1 = 0x0000FFFF captured -> line 40: x 16..143 = 0x00, x 144..271 = 0xFF. ch0 rows unaffected.
- data_i changed mid-frame 1 -> frame 1 overlay unchanged; new value appears from frame 2 line 16.
- m_axi_ready_i low 5 cycles with input valid streaming -> s_axi_ready_o low after 1 beat, m_axi_data_o stable; no beat lost or duplicated over 1600 pixels.
- MONIM_OVL_LINE_CHK_EN defined:
  - Line of 500 beats with last on beat 500 -> line_err_o = 1 and stays 1.
  - After arst_i it is 0; a clean 800-beat line keeps it 0.
